// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter handing one byte at a time from four
//            requesters to a single UART transmitter, with start timeout.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [1:0]  grant_id,
  output logic        ctrl_busy,
  output logic        tx_timeout
);

  localparam logic [7:0] c_count_limit = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_rr_ptr;
  logic [1:0]  r_grant_id;
  logic [7:0]  r_tx_data;
  logic [7:0]  r_count;
  logic        r_tx_timeout;

  logic        w_found;
  logic [1:0]  w_winner;
  logic        w_grant;
  logic        w_timeout_hit;

  // r_rr_ptr holds the first index to search, i.e. last grant + 1.
  always_comb begin
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    for (int i = 0; i < 4; i++) begin
      if (!w_found && req[r_rr_ptr + 2'(i)]) begin
        w_found  = 1'b1;
        w_winner = r_rr_ptr + 2'(i);
      end
    end
  end

  assign w_grant = (r_state == IDLE) && !tx_busy && w_found;

  always_comb begin
    w_next_state  = r_state;
    w_timeout_hit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) w_next_state = START;
      end
      START: begin
        w_next_state = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A busy indication in the limit cycle takes precedence over timeout.
        if (tx_busy) begin
          w_next_state = WAIT_DONE;
        end else if (r_count == c_count_limit) begin
          w_next_state  = IDLE;
          w_timeout_hit = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rr_ptr     <= 2'd0;
      r_grant_id   <= 2'd0;
      r_tx_data    <= 8'd0;
      r_count      <= 8'd0;
      r_tx_timeout <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_tx_timeout <= w_timeout_hit;
      if (w_grant) begin
        r_grant_id <= w_winner;
        r_rr_ptr   <= w_winner + 2'd1;
        r_tx_data  <= req_data[{w_winner, 3'b000} +: 8];
      end
      // Clearing in START means the counter reads 0 on the first WAIT_BUSY cycle.
      if (r_state == START) begin
        r_count <= 8'd0;
      end else if (r_state == WAIT_BUSY && r_count != 8'hFF) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign tx_start   = (r_state == START);
  assign ack        = tx_start ? (4'b0001 << r_grant_id) : 4'b0000;
  assign tx_data    = r_tx_data;
  assign grant_id   = r_grant_id;
  assign ctrl_busy  = (r_state != IDLE);
  assign tx_timeout = r_tx_timeout;

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles to wait for tx_busy to rise after tx_start (legal range 2..255).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req  input  4  per-requester transmit request; bit i = requester i.
REQ-005 req_data  input  32  byte for requester i on bits [8i+7:8i].
REQ-006 ack  output  4  one-cycle pulse on bit i when requester i's byte is handed to the transmitter.
REQ-007 tx_start  output  1  start strobe to the UART transmitter.
REQ-008 tx_data  output  8  byte to the UART transmitter; valid while tx_start=1.
REQ-009 tx_busy  input  1  transmitter busy status (o_busy of the transmitter).
REQ-010 grant_id  output  2  index of the requester currently or last granted.
REQ-011 ctrl_busy  output  1  high whenever the state is not IDLE.
REQ-012 tx_timeout  output  1  one-cycle pulse when tx_busy fails to rise within TIMEOUT_CYCLES.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-014 IDLE: if tx_busy=0 and req!=0, select a winner, latch its byte and index, go to START; otherwise stay in IDLE.
REQ-015 IDLE with tx_busy=1: no grant, even if req!=0.
REQ-016 Arbitration SHALL be round-robin: search order starts at (last_grant+1) mod 4 and wraps 3->0; the pointer after reset is 0, so requester 0 has first priority.
REQ-017 last_grant SHALL update only when a grant is made in IDLE.
REQ-018 START (exactly one cycle): tx_start=1, tx_data=latched byte, ack[grant_id]=1, all other ack bits 0; next state WAIT_BUSY.
REQ-019 Latency: req sampled in IDLE at edge N -> tx_start/ack high in the cycle after edge N (one cycle).
REQ-020 WAIT_BUSY: a counter starts at 0 and increments each cycle; tx_busy=1 -> WAIT_DONE; counter = TIMEOUT_CYCLES-1 with tx_busy=0 -> tx_timeout pulse, go to IDLE.
REQ-021 If tx_busy=1 and the counter reaches its limit in the same cycle, tx_busy SHALL win: go to WAIT_DONE, no timeout.
REQ-022 WAIT_DONE: tx_busy=0 -> IDLE; no counter limit.
REQ-023 tx_data SHALL hold the latched byte from START until the next grant; changes on req_data after the grant have no effect.
REQ-024 A requester SHALL hold req and req_data stable until ack; deasserting req before grant withdraws it without side effects.
REQ-025 A requester still asserting req after its ack is treated as a new request and competes normally in the next IDLE.
REQ-026 Back-to-back: the minimum spacing between successive tx_start pulses is 4 cycles (START, WAIT_BUSY>=1, WAIT_DONE>=1, IDLE).
REQ-027 ack, tx_start and tx_timeout SHALL never be high outside the single cycle defined above.
REQ-028 The counter SHALL be wide enough for 255 and clear on entry to WAIT_BUSY.

Reset
REQ-029 While reset=1 (asynchronous): state=IDLE, tx_start=0, tx_data=0, ack=0, grant_id=0, ctrl_busy=0, tx_timeout=0, counter=0, round-robin pointer=0.
REQ-030 Reset asserted mid-transfer SHALL drop tx_start and ack immediately, without waiting for a clock edge; the transmitter itself is not aborted.
REQ-031 After reset release, no grant is made until tx_busy=0 (REQ-015).

Verification
REQ-032 Single request: req=4'b0100, req_data[23:16]=8'hA5, tx_busy idle -> one cycle later tx_start=1, tx_data=8'hA5, ack=4'b0100, grant_id=2.
REQ-033 Round-robin: req=4'b1111 held, the transmitter model busies for 10 cycles per byte -> grant order 0,1,2,3,0, each ack exactly once per grant.
REQ-034 Wrap: last grant 3, req=4'b1001 -> grant 0; next grant 3.
REQ-035 Timeout: TIMEOUT_CYCLES=16, tx_busy held 0 after tx_start -> tx_timeout pulses 16 cycles after entry to WAIT_BUSY, FSM returns to IDLE, ctrl_busy=0.
REQ-036 Reset mid-WAIT_DONE with tx_busy=1 and req=4'b0010 -> outputs clear asynchronously; after release, no tx_start until tx_busy=0, then grant_id=1.
REQ-037 Withdraw: req[1] pulses 1 cycle while tx_busy=1 -> no ack[1] and no tx_start issued.
